// File: rtl/motor_mode_ctrl_pkg.sv
// Shared encodings for the motor mode controller: mode and timer-selection
// enumerations plus the width of the remaining-seconds counter.
package motor_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    TMR_NONE = 2'd0,
    TMR_T1   = 2'd1,
    TMR_T2   = 2'd2,
    TMR_T3   = 2'd3
  } timer_t;

  localparam int REMAIN_W = 9;

endpackage

// File: rtl/motor_mode_ctrl_pwm_gen.sv
// PWM generator: free-running period counter with a registered duty compare.
// The first enabled edge only arms the counter, so o_pwm lags the enable by one clock.
module pwm_gen #(
  parameter int PERIOD = 4000,
  parameter int CNT_W  = $clog2(PERIOD)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_pwm
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] duty_reg;
  logic             en_reg;
  logic             pwm_reg;

  // duty_reg captures the duty of the mode being entered, so the compare
  // always uses the duty of the mode currently presented on o_mode.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_reg  <= '0;
      duty_reg <= '0;
      en_reg   <= 1'b0;
      pwm_reg  <= 1'b0;
    end else begin
      en_reg   <= i_enable;
      duty_reg <= i_duty;
      if (!i_enable) begin
        cnt_reg <= '0;
        pwm_reg <= 1'b0;
      end else if (en_reg) begin
        pwm_reg <= (cnt_reg < duty_reg);
        cnt_reg <= (cnt_reg == CNT_W'(PERIOD - 1)) ? '0 : cnt_reg + 1'b1;
      end
    end
  end

  assign o_pwm = pwm_reg;

endmodule

// File: rtl/motor_mode_ctrl.sv
// Motor mode controller: mode and timer FSMs driven by button pulses, a
// one-second prescaler for the auto-off countdown, and the motor PWM.
module motor_mode_ctrl
  import motor_mode_ctrl_pkg::*;
#(
  parameter int PWM_PERIOD   = 4000,
  parameter int DUTY_LOW     = 1000,
  parameter int DUTY_MID     = 2000,
  parameter int DUTY_HIGH    = 3000,
  parameter int TICK_PER_SEC = 100_000_000,
  parameter int T1_SEC       = 60,
  parameter int T2_SEC       = 180,
  parameter int T3_SEC       = 300
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_btn_mode,
  input  logic                i_btn_timer,
  input  logic                i_btn_stop,
  output logic                o_pwm,
  output logic [1:0]          o_mode,
  output logic [1:0]          o_timer_sel,
  output logic [REMAIN_W-1:0] o_remain_sec,
  output logic                o_running
);

  localparam int CNT_W   = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int PRESC_W = (TICK_PER_SEC > 1) ? $clog2(TICK_PER_SEC) : 1;

  mode_t               mode_reg, mode_next;
  timer_t              timer_reg, timer_next;
  logic [REMAIN_W-1:0] remain_reg, remain_next;
  logic [PRESC_W-1:0]  presc_reg, presc_next;
  logic                running_reg;
  logic                counting;
  logic                tick;
  logic                expire;
  logic [CNT_W-1:0]    duty_next;

  function automatic logic [REMAIN_W-1:0] preset(input timer_t sel);
    case (sel)
      TMR_T1:  preset = REMAIN_W'(T1_SEC);
      TMR_T2:  preset = REMAIN_W'(T2_SEC);
      TMR_T3:  preset = REMAIN_W'(T3_SEC);
      default: preset = '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] duty_of(input mode_t m);
    case (m)
      MODE_LOW:  duty_of = CNT_W'(DUTY_LOW);
      MODE_MID:  duty_of = CNT_W'(DUTY_MID);
      MODE_HIGH: duty_of = CNT_W'(DUTY_HIGH);
      default:   duty_of = '0;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mode_reg    <= MODE_OFF;
      timer_reg   <= TMR_NONE;
      remain_reg  <= '0;
      presc_reg   <= '0;
      running_reg <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      timer_reg   <= timer_next;
      remain_reg  <= remain_next;
      presc_reg   <= presc_next;
      running_reg <= (mode_next != MODE_OFF);
    end
  end

  always_comb begin
    mode_next   = mode_reg;
    timer_next  = timer_reg;
    remain_next = remain_reg;
    presc_next  = presc_reg;

    counting = (timer_reg != TMR_NONE) && (mode_reg != MODE_OFF);
    tick     = counting && (presc_reg == PRESC_W'(TICK_PER_SEC - 1));
    expire   = tick && (remain_reg == REMAIN_W'(1));

    if (counting) begin
      presc_next = tick ? '0 : presc_reg + 1'b1;
    end
    if (tick) begin
      remain_next = remain_reg - 1'b1;
    end

    // Stop outranks expiry, which outranks a mode advance.
    if (i_btn_stop || expire) begin
      mode_next = MODE_OFF;
    end else if (i_btn_mode) begin
      mode_next = mode_t'(mode_reg + 2'd1);
    end

    // Timer pulses are judged against the mode being entered, not the current one.
    if (mode_next == MODE_OFF) begin
      timer_next  = TMR_NONE;
      remain_next = '0;
      presc_next  = '0;
    end else if (i_btn_timer) begin
      timer_next  = timer_t'(timer_reg + 2'd1);
      remain_next = preset(timer_next);
      presc_next  = '0;
    end

    duty_next = duty_of(mode_next);
  end

  pwm_gen #(
    .PERIOD (PWM_PERIOD),
    .CNT_W  (CNT_W)
  ) u_pwm_gen (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (mode_next != MODE_OFF),
    .i_duty    (duty_next),
    .o_pwm     (o_pwm)
  );

  assign o_mode       = mode_reg;
  assign o_timer_sel  = timer_reg;
  assign o_remain_sec = remain_reg;
  assign o_running    = running_reg;

endmodule
